// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO for any depth (non-power-of-two allowed). It has an occupancy count,
// almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow
// flags, and either a registered read or a first-word-fall-through read.
module sync_fifo_flex #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = 12,
   parameter int unsigned AE_THRESH = 4,
   parameter int unsigned FWFT      = 0,
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_dout_valid,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_almost_full,
   output logic             o_almost_empty,
   output logic [CNT_W-1:0] o_count,
   output logic             o_overflow,
   output logic             o_underflow,
   input  logic             i_err_clr
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Reject parameter sets the flag and index logic cannot represent.
   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_flex: DEPTH must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_flex: AF_THRESH must be in 1..DEPTH");
   end
   if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flex: AE_THRESH must be in 0..DEPTH-1");
   end

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [IDX_W-1:0] r_wr_idx;
   logic [IDX_W-1:0] r_rd_idx;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic             r_underflow;

   logic w_full;
   logic w_empty;
   logic w_wa;
   logic w_ra;

   // Explicit wrap so that non-power-of-two depths never index past DEPTH-1.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
   endfunction

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_wa    = i_wr_en & ~w_full;
   assign w_ra    = i_rd_en & ~w_empty;

   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (r_count >= CNT_W'(AF_THRESH));
   assign o_almost_empty = (r_count <= CNT_W'(AE_THRESH));
   assign o_count        = r_count;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

   // Storage array: not reset, and written only by an accepted write outside reset/flush.
   always_ff @(posedge i_clk) begin
      if (!i_rst && !i_flush && w_wa) begin
         r_mem[r_wr_idx] <= i_din;
      end
   end

   // Indices and occupancy. Reset and flush both empty the FIFO.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_count  <= '0;
      end else begin
         if (w_wa) r_wr_idx <= next_idx(r_wr_idx);
         if (w_ra) r_rd_idx <= next_idx(r_rd_idx);
         if (w_wa && !w_ra) begin
            r_count <= r_count + 1'b1;
         end else if (w_ra && !w_wa) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Sticky error flags. A new error beats err_clr, and flush leaves the flags untouched.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (!i_flush) begin
         r_overflow  <= (i_wr_en & w_full) | (r_overflow & ~i_err_clr);
         r_underflow <= (i_rd_en & w_empty) | (r_underflow & ~i_err_clr);
      end
   end

   if (FWFT == 0) begin : g_reg_out
      logic [WIDTH-1:0] r_dout;
      logic             r_dout_valid;

      // Registered read: a pop loads the head word and raises valid for one cycle.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
         end else if (i_flush) begin
            r_dout_valid <= 1'b0;
         end else if (w_ra) begin
            r_dout       <= r_mem[r_rd_idx];
            r_dout_valid <= 1'b1;
         end else begin
            r_dout_valid <= 1'b0;
         end
      end

      assign o_dout       = r_dout;
      assign o_dout_valid = r_dout_valid;
   end else begin : g_fwft_out
      // Head word is visible whenever the FIFO holds data. A pop consumes it.
      assign o_dout       = r_mem[r_rd_idx];
      assign o_dout_valid = ~w_empty;
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex. It runs a registered-read instance and an FWFT instance
// side by side on the same stimulus. Both are checked every cycle against a queue model,
// and directed sequences add literal expectations.
module tb_sync_fifo_flex;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 5;
   localparam int unsigned AF    = 4;
   localparam int unsigned AE    = 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic             rd_en = 1'b0;
   logic             err_clr = 1'b0;

   logic [WIDTH-1:0] dout0, dout1;
   logic             dv0, dv1, full0, full1, empty0, empty1;
   logic             af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
   logic [CNT_W-1:0] cnt0, cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: contents as a queue, sticky flags, registered-read output.
   logic [WIDTH-1:0] m_q[$];
   bit               m_ovf, m_udf, m_dv;
   logic [WIDTH-1:0] m_dout;

   always #5 clk = ~clk;

   sync_fifo_flex #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
   ) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_din(din),
      .i_rd_en(rd_en), .o_dout(dout0), .o_dout_valid(dv0), .o_full(full0),
      .o_empty(empty0), .o_almost_full(af0), .o_almost_empty(ae0), .o_count(cnt0),
      .o_overflow(ovf0), .o_underflow(udf0), .i_err_clr(err_clr)
   );

   sync_fifo_flex #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
   ) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_din(din),
      .i_rd_en(rd_en), .o_dout(dout1), .o_dout_valid(dv1), .o_full(full1),
      .o_empty(empty1), .o_almost_full(af1), .o_almost_empty(ae1), .o_count(cnt1),
      .o_overflow(ovf1), .o_underflow(udf1), .i_err_clr(err_clr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) begin
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
         end
      end
   endtask

   // Advance the model by the effect of the inputs presented for the coming edge.
   task automatic model_step();
      int  n;
      bit  mfull, mempty, new_ovf, new_udf;
      if (rst) begin
         m_q.delete();
         m_ovf  = 0;
         m_udf  = 0;
         m_dout = '0;
         m_dv   = 0;
      end else if (flush) begin
         m_q.delete();
         m_dv = 0;
      end else begin
         n       = m_q.size();
         mfull   = (n == DEPTH);
         mempty  = (n == 0);
         new_ovf = wr_en && mfull;
         new_udf = rd_en && mempty;
         if (rd_en && !mempty) begin
            m_dout = m_q.pop_front();
            m_dv   = 1;
         end else begin
            m_dv = 0;
         end
         if (wr_en && !mfull) m_q.push_back(din);
         m_ovf = new_ovf || (m_ovf && !err_clr);
         m_udf = new_udf || (m_udf && !err_clr);
      end
   endtask

   task automatic compare_all();
      int n;
      n = m_q.size();
      chk("count0", 32'(cnt0), n);
      chk("count1", 32'(cnt1), n);
      chk("full0", 32'(full0), 32'(n == DEPTH));
      chk("full1", 32'(full1), 32'(n == DEPTH));
      chk("empty0", 32'(empty0), 32'(n == 0));
      chk("empty1", 32'(empty1), 32'(n == 0));
      chk("afull0", 32'(af0), 32'(n >= AF));
      chk("afull1", 32'(af1), 32'(n >= AF));
      chk("aempty0", 32'(ae0), 32'(n <= AE));
      chk("aempty1", 32'(ae1), 32'(n <= AE));
      chk("ovf0", 32'(ovf0), 32'(m_ovf));
      chk("ovf1", 32'(ovf1), 32'(m_ovf));
      chk("udf0", 32'(udf0), 32'(m_udf));
      chk("udf1", 32'(udf1), 32'(m_udf));
      chk("dvalid0", 32'(dv0), 32'(m_dv));
      chk("dout0", 32'(dout0), 32'(m_dout));
      chk("dvalid1", 32'(dv1), 32'(n != 0));
      if (n != 0) chk("dout1", 32'(dout1), 32'(m_q[0]));
   endtask

   // One clock: model the edge, let the DUTs take it, then compare away from the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic drive(input bit w, input logic [WIDTH-1:0] d, input bit r);
      rst     = 1'b0;
      flush   = 1'b0;
      err_clr = 1'b0;
      wr_en   = w;
      din     = d;
      rd_en   = r;
   endtask

   task automatic do_write(input logic [WIDTH-1:0] d);
      drive(1'b1, d, 1'b0);
      tick();
   endtask

   task automatic do_read();
      drive(1'b0, '0, 1'b1);
      tick();
   endtask

   task automatic do_clr();
      drive(1'b0, '0, 1'b0);
      err_clr = 1'b1;
      tick();
   endtask

   initial begin
      int p;
      // Reset state.
      rst = 1'b1;
      tick();
      tick();
      chk("rst_count", 32'(cnt0), 0);
      chk("rst_empty", 32'(empty0), 1);
      chk("rst_aempty", 32'(ae0), 1);
      chk("rst_afull", 32'(af0), 0);
      chk("rst_dout", 32'(dout0), 0);
      chk("rst_dvalid", 32'(dv0), 0);

      // Fill to full, overflow on the sixth write, then drain in order.
      for (int i = 0; i < 5; i++) do_write(8'h11 + 8'(i));
      chk("fill_count", 32'(cnt0), 5);
      chk("fill_full", 32'(full0), 1);
      chk("fill_afull", 32'(af1), 1);
      do_write(8'h16);
      chk("ovf_set", 32'(ovf0), 1);
      chk("ovf_count", 32'(cnt1), 5);
      for (int i = 0; i < 5; i++) begin
         chk("fwft_head", 32'(dout1), 32'h11 + i);
         do_read();
         chk("drain_data", 32'(dout0), 32'h11 + i);
      end
      chk("drain_empty", 32'(empty0), 1);

      // Simultaneous read/write when full, then when empty.
      do_clr();
      for (int i = 0; i < 5; i++) do_write(8'h11 + 8'(i));
      drive(1'b1, 8'h99, 1'b1);
      tick();
      chk("fullrw_dout", 32'(dout0), 32'h11);
      chk("fullrw_count", 32'(cnt0), 4);
      chk("fullrw_ovf", 32'(ovf1), 1);
      for (int i = 0; i < 4; i++) do_read();
      do_clr();
      drive(1'b1, 8'h42, 1'b1);
      tick();
      chk("emptyrw_count", 32'(cnt0), 1);
      chk("emptyrw_udf", 32'(udf0), 1);
      do_read();
      do_clr();

      // Read latency in both output modes.
      do_write(8'hA5);
      chk("fwft_dout", 32'(dout1), 32'hA5);
      chk("fwft_valid", 32'(dv1), 1);
      chk("reg_novalid", 32'(dv0), 0);
      do_read();
      chk("reg_dout", 32'(dout0), 32'hA5);
      chk("reg_valid", 32'(dv0), 1);

      // Flush beats a write. err_clr loses to a new underflow.
      for (int i = 0; i < 3; i++) do_write(8'h50 + 8'(i));
      drive(1'b1, 8'h77, 1'b0);
      flush = 1'b1;
      tick();
      chk("flush_count", 32'(cnt0), 0);
      chk("flush_empty", 32'(empty1), 1);
      drive(1'b0, '0, 1'b0);
      tick();
      chk("flush_nostore", 32'(cnt1), 0);
      do_read();
      drive(1'b0, '0, 1'b1);
      err_clr = 1'b1;
      tick();
      chk("clr_vs_udf", 32'(udf0), 1);
      do_clr();
      chk("clr_done", 32'(udf1), 0);

      // Reset while holding data, then normal operation resumes.
      for (int i = 0; i < 3; i++) do_write(8'h60 + 8'(i));
      drive(1'b0, '0, 1'b0);
      rst = 1'b1;
      tick();
      chk("mrst_count", 32'(cnt0), 0);
      chk("mrst_dout", 32'(dout0), 0);
      do_write(8'h33);
      do_read();
      chk("mrst_data", 32'(dout0), 32'h33);

      // Index wrap over three rounds of four.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) do_write(8'h20 + 8'(r * 4 + i));
         for (int i = 0; i < 4; i++) begin
            do_read();
            chk("wrap_data", 32'(dout0), 32'h20 + r * 4 + i);
         end
      end

      // Random traffic with shifting write bias to visit both full and empty.
      for (int ph = 0; ph < 4; ph++) begin
         p = (ph == 0) ? 80 : (ph == 2) ? 20 : 50;
         for (int c = 0; c < 800; c++) begin
            drive(($urandom_range(99) < p), 8'($urandom), ($urandom_range(99) < 100 - p));
            flush   = ($urandom_range(59) == 0);
            err_clr = !flush && ($urandom_range(39) == 0);
            rst     = ($urandom_range(299) == 0);
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
